// File: rtl/rand_history.sv
`default_nettype none
// ============================================================================
//  Module   : rand_history
//  Purpose  : Result recorder for the random-number generator. Detects the
//             end of each roll (falling edge of the changing flag), stores the
//             final value in a circular history buffer, and drives the display
//             either live from the generator or from stored results stepped
//             newest-to-oldest on user request.
//  Ports    : i_clk        - system clock
//             i_rst_n      - asynchronous active-low reset
//             i_random     - generator value
//             i_changing   - generator busy flag
//             i_recall     - single-cycle pulse, step through history
//             i_clear      - single-cycle pulse, empty history
//             o_display    - value to show
//             o_recalling  - high while showing a stored entry
//             o_index      - age of shown entry (0 = newest), 0 when live
//             o_count      - number of valid entries, 0..DEPTH
//             o_new_result - one-cycle pulse after each capture
//  Revision : 1.0 - initial release
// ============================================================================
module rand_history #(
  parameter int DEPTH = 8,
  parameter int W     = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [W-1:0]  i_random,
  input  logic          i_changing,
  input  logic          i_recall,
  input  logic          i_clear,
  output logic [W-1:0]  o_display,
  output logic          o_recalling,
  output logic [AW-1:0] o_index,
  output logic [AW:0]   o_count,
  output logic          o_new_result
);

  localparam logic [0:0] c_S_LIVE   = 1'b0;
  localparam logic [0:0] c_S_RECALL = 1'b1;
  localparam logic [AW:0] c_FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0] c_ONE     = (AW+1)'(1);

  logic [0:0]    r_state;
  logic          r_chg_d;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_count;
  logic [AW-1:0] r_offset;
  logic [W-1:0]  r_mem [DEPTH];
  logic          r_new;

  logic          w_fall;
  logic          w_rise;
  logic [AW-1:0] w_rd_ptr;
  logic          w_more;

  assign w_fall   = r_chg_d & ~i_changing;
  assign w_rise   = ~r_chg_d & i_changing;
  // Newest entry sits just behind the write pointer; AW-bit arithmetic
  // gives the modulo-DEPTH wrap for free.
  assign w_rd_ptr = r_wr_ptr - AW'(1) - r_offset;
  // Full-width compare so count == DEPTH is handled correctly.
  assign w_more   = (({1'b0, r_offset} + c_ONE) < r_count);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= c_S_LIVE;
      r_chg_d  <= 1'b0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_offset <= '0;
      r_new    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_chg_d <= i_changing;
      r_new   <= 1'b0;
      // Priority: clear > capture > rise > recall; losers are dropped.
      if (i_clear) begin
        r_count  <= '0;
        r_wr_ptr <= '0;
        r_offset <= '0;
        r_state  <= c_S_LIVE;
      end else if (w_fall) begin
        r_mem[r_wr_ptr] <= i_random;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
        if (r_count != c_FULL) begin
          r_count <= r_count + c_ONE;
        end
        r_offset <= '0;
        r_state  <= c_S_LIVE;
        r_new    <= 1'b1;
      end else if (w_rise) begin
        r_offset <= '0;
        r_state  <= c_S_LIVE;
      end else if (i_recall) begin
        if (r_state == c_S_LIVE) begin
          if (r_count != '0) begin
            r_state  <= c_S_RECALL;
            r_offset <= '0;
          end
        end else if (w_more) begin
          r_offset <= r_offset + AW'(1);
        end else begin
          // Stepped past the oldest entry: wrap back to live.
          r_state  <= c_S_LIVE;
          r_offset <= '0;
        end
      end
    end
  end

  assign o_recalling  = (r_state == c_S_RECALL);
  assign o_index      = o_recalling ? r_offset : '0;
  assign o_display    = o_recalling ? r_mem[w_rd_ptr] : i_random;
  assign o_count      = r_count;
  assign o_new_result = r_new;

endmodule
`default_nettype wire

// File: tb/tb_rand_history.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rand_history
//  Purpose  : Directed self-checking bench for rand_history (DEPTH=8, W=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rand_history;

  logic       i_clk;
  logic       i_rst_n;
  logic [3:0] i_random;
  logic       i_changing;
  logic       i_recall;
  logic       i_clear;
  logic [3:0] o_display;
  logic       o_recalling;
  logic [2:0] o_index;
  logic [3:0] o_count;
  logic       o_new_result;

  int n_checks = 0;
  int n_err    = 0;

  rand_history #(.DEPTH(8), .W(4)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_random     (i_random),
    .i_changing   (i_changing),
    .i_recall     (i_recall),
    .i_clear      (i_clear),
    .o_display    (o_display),
    .o_recalling  (o_recalling),
    .o_index      (o_index),
    .o_count      (o_count),
    .o_new_result (o_new_result)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs and checks happen 1 ns after the rising edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // One complete roll ending on v; checks the capture pulse and count.
  task automatic roll(input logic [3:0] v, input int exp_count);
    i_changing = 1'b1;
    i_random   = 4'hF;
    tick();
    i_random   = v;
    i_changing = 1'b0;
    tick();
    chk("roll_new_pulse", 32'(o_new_result), 32'd1);
    chk("roll_count", 32'(o_count), 32'(exp_count));
    tick();
    chk("roll_new_drop", 32'(o_new_result), 32'd0);
  endtask

  task automatic recall_pulse();
    i_recall = 1'b1;
    tick();
    i_recall = 1'b0;
  endtask

  task automatic clear_pulse();
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
  endtask

  task automatic expect_recall(input logic [3:0] d, input logic [2:0] idx);
    chk("rec_recalling", 32'(o_recalling), 32'd1);
    chk("rec_index", 32'(o_index), 32'(idx));
    chk("rec_display", 32'(o_display), 32'(d));
  endtask

  task automatic expect_live();
    chk("live_recalling", 32'(o_recalling), 32'd0);
    chk("live_index", 32'(o_index), 32'd0);
    chk("live_display", 32'(o_display), 32'(i_random));
  endtask

  initial begin
    // ---------------- reset / empty ----------------
    i_rst_n    = 1'b0;
    i_random   = 4'h7;
    i_changing = 1'b0;
    i_recall   = 1'b0;
    i_clear    = 1'b0;
    #1;
    chk("rst_recalling", 32'(o_recalling), 32'd0);
    chk("rst_count", 32'(o_count), 32'd0);
    chk("rst_new", 32'(o_new_result), 32'd0);
    chk("rst_display", 32'(o_display), 32'h7);
    tick();
    tick();
    i_rst_n = 1'b1;
    tick();
    recall_pulse();
    chk("empty_recall_ignored", 32'(o_recalling), 32'd0);
    chk("empty_display", 32'(o_display), 32'h7);
    chk("empty_count", 32'(o_count), 32'd0);

    // ---------------- capture three rolls ----------------
    roll(4'h3, 1);
    roll(4'h9, 2);
    roll(4'hC, 3);
    i_random = 4'h1;
    recall_pulse(); expect_recall(4'hC, 3'd0);
    recall_pulse(); expect_recall(4'h9, 3'd1);
    recall_pulse(); expect_recall(4'h3, 3'd2);
    recall_pulse(); expect_live();

    // ---------------- interrupt by new roll ----------------
    recall_pulse();
    recall_pulse(); expect_recall(4'h9, 3'd1);
    i_changing = 1'b1;
    i_random   = 4'hE;
    tick();
    expect_live();
    i_random = 4'h2;
    #1;
    chk("live_follows", 32'(o_display), 32'h2);
    i_random   = 4'hA;
    i_changing = 1'b0;
    tick();
    chk("interrupt_capture_count", 32'(o_count), 32'd4);
    tick();

    // ---------------- clear, then wrap/full ----------------
    clear_pulse();
    chk("clear_count", 32'(o_count), 32'd0);
    for (int i = 0; i < 10; i++) begin
      roll(4'(i), (i + 1 > 8) ? 8 : i + 1);
    end
    i_random = 4'h0;
    for (int k = 0; k < 8; k++) begin
      recall_pulse();
      expect_recall(4'(9 - k), 3'(k));
    end
    recall_pulse(); expect_live();

    // ---------------- simultaneous events ----------------
    clear_pulse();
    roll(4'h1, 1);
    roll(4'h2, 2);
    i_changing = 1'b1;
    tick();
    i_random   = 4'h5;
    i_changing = 1'b0;
    i_recall   = 1'b1;
    tick();
    i_recall   = 1'b0;
    chk("sim_recall_dropped", 32'(o_recalling), 32'd0);
    chk("sim_count", 32'(o_count), 32'd3);
    chk("sim_new", 32'(o_new_result), 32'd1);
    i_random = 4'h0;
    recall_pulse(); expect_recall(4'h5, 3'd0);
    i_changing = 1'b1;
    tick();
    chk("sim_rise_live", 32'(o_recalling), 32'd0);
    i_random   = 4'h6;
    i_changing = 1'b0;
    i_clear    = 1'b1;
    tick();
    i_clear    = 1'b0;
    chk("clrfall_count", 32'(o_count), 32'd0);
    chk("clrfall_new", 32'(o_new_result), 32'd0);
    tick();
    chk("clrfall_new_late", 32'(o_new_result), 32'd0);
    chk("clrfall_count_late", 32'(o_count), 32'd0);

    // ---------------- async reset mid-recall ----------------
    roll(4'h4, 1);
    roll(4'h5, 2);
    roll(4'h6, 3);
    i_random = 4'h8;
    recall_pulse();
    recall_pulse();
    recall_pulse(); expect_recall(4'h4, 3'd2);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("arst_recalling", 32'(o_recalling), 32'd0);
    chk("arst_index", 32'(o_index), 32'd0);
    chk("arst_count", 32'(o_count), 32'd0);
    chk("arst_display", 32'(o_display), 32'h8);
    tick();
    #2;
    i_rst_n = 1'b1;
    tick();
    recall_pulse();
    chk("post_rst_recall_ignored", 32'(o_recalling), 32'd0);
    chk("post_rst_count", 32'(o_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rand_history.md
# rand_history

Result recorder that sits on the consumer side of the random-number generator's `o_random_out` / `o_changing` interface. It detects the end of each roll (falling edge of the changing flag) and stores the final value in a circular history buffer. It drives the 4-bit display either live from the generator or, on user request, from stored results stepped newest-to-oldest. All state is local; the generator is unmodified.

## Interface
- `DEPTH`, 8: history entries; power of two, ≥ 2.
- `W`, 4: result width; matches generator output.
- `i_clk`  in  1  system clock.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_random`  in  W  generator value (`o_random_out`).
- `i_changing`  in  1  generator busy flag (`o_changing`).
- `i_recall`  in  1  single-cycle pulse (debounced upstream): step history.
- `i_clear`  in  1  single-cycle pulse: empty history.
- `o_display`  out  W  value to show on the display.
- `o_recalling`  out  1  high while showing a stored entry.
- `o_index`  out  log2(DEPTH)  age of shown entry (0 = newest); 0 when live.
- `o_count`  out  log2(DEPTH)+1  valid entries, 0..DEPTH.
- `o_new_result`  out  1  one-cycle pulse after each capture.

## Operation
- Registers: `state` (S_LIVE/S_RECALL), `chg_d` (previous i_changing), `wr_ptr`, `count`, `offset`, `mem[DEPTH]`, `new_q`.
- Edge detect: `fall = chg_d & ~i_changing`; `rise = ~chg_d & i_changing`.
- Capture on `fall`: `mem[wr_ptr] <= i_random`; `wr_ptr` increments mod DEPTH; `count` increments and saturates at DEPTH. When full, the oldest entry is overwritten. A capture forces S_LIVE and sets offset 0.
- S_LIVE: `o_display = i_random` (combinational pass-through); `o_recalling=0`; `o_index=0`.
  - `i_recall` with count>0 → S_RECALL, offset 0.
  - `i_recall` with count==0 is ignored.
- S_RECALL: `o_display = mem[(wr_ptr-1-offset) mod DEPTH]`; `o_recalling=1`; `o_index=offset`.
  - `i_recall` with offset+1 < count: offset increments.
  - `i_recall` with offset+1 == count → S_LIVE, offset 0. The step wraps back to live after the oldest entry.
  - `rise` (new roll started) → S_LIVE, offset 0.
- `i_clear`: count 0, wr_ptr 0, offset 0, S_LIVE. mem contents are retained but unreachable.
- Priority per cycle: clear > capture > rise > recall. A lower-priority event in the same cycle is dropped, not deferred. Exception: `i_clear` and `fall` in the same cycle drops the capture and produces no `o_new_result`.
- Pointer/offset arithmetic is modulo DEPTH. The `count` compare uses the full log2(DEPTH)+1 bits.

## Timing
- Reset values (asynchronous): state S_LIVE, chg_d 0, wr_ptr 0, count 0, offset 0, new_q 0, all mem entries 0.
  - During and after reset: `o_recalling=0`, `o_index=0`, `o_count=0`, `o_new_result=0`, `o_display=i_random`.
- Capture latency:
  - `fall` is seen in the first cycle with i_changing low (cycle c); mem and pointers update at the end of c.
  - `o_count` updates in c+1, and `o_new_result` is high in c+1 only.
- Recall latency: `i_recall` sampled at the end of cycle c; `o_recalling`, `o_index` and `o_display` reflect the new state in c+1.
- If i_changing is high out of reset, no capture occurs until the first 1→0 transition.
- A 1-cycle low glitch on i_changing counts as a roll end and is captured.
- Reset asserted mid-recall or mid-capture returns the block to the reset values immediately; a pending write is lost.
- All outputs except `o_display` in S_LIVE are registered or decoded from registers.

## Test plan
- Reset/empty: release reset with i_changing=0 and i_random=4'h7, pulse i_recall → o_display=7, o_recalling=0, o_count=0 throughout.
- Capture: three rolls ending on 3, 9, C → o_new_result pulses 3 times, o_count=3. Pulse recall ×4 → display C(idx0), 9(idx1), 3(idx2), then live with o_recalling=0.
- Wrap/full: DEPTH=8, ten rolls ending on values 0..9 → o_count=8. Recall sequence shows 9,8,…,2, then live.
- Interrupt: in S_RECALL at idx1, raise i_changing → next cycle o_recalling=0, o_display follows i_random.
- Simultaneous: i_recall in the same cycle as fall (value 5) → capture wins, state S_LIVE, o_count+1, no recall step. i_clear in the same cycle as fall → o_count=0, no o_new_result.
- Async reset mid-recall: assert i_rst_n=0 while o_index=2, between clock edges → outputs reach reset values without waiting for a clock edge. After release, recall is ignored (o_count=0).
